alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Registered, parametrised operand-select stage for the multi-cycle datapath. It picks ALU source 1 and source 2 from `NSRC` candidate buses each, or from a locally held copy of the last ALU result. It latches both operands into a single-entry valid/ready output register and flags illegal select codes. It sits between register-file read/decode and the ALU, and replaces the per-operand combinational source muxes.

## Interface
Parameters:
- `WIDTH`, 32, datapath width in bits.
- `NSRC`, 3, candidate buses per operand; code 0 selects constant zero, codes 1..NSRC select bus lanes 0..NSRC-1.
- `SEL_W`, `$clog2(NSRC+2)`, select-code width (derived; do not override).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  selects and buses valid this cycle.
- `in_ready`  out  1  stage can accept.
- `src1_sel`  in  SEL_W  operand-1 select code.
- `src2_sel`  in  SEL_W  operand-2 select code.
- `src1_bus`  in  NSRC*WIDTH  operand-1 candidates; lane k at bits [k*WIDTH +: WIDTH] (e.g. pc, rf_rdata1, ...).
- `src2_bus`  in  NSRC*WIDTH  operand-2 candidates (e.g. rf_rdata2, imm, ...).
- `res_we`  in  1  write `res_in` into the feedback register.
- `res_in`  in  WIDTH  ALU result to hold.
- `flush`  in  1  discard held operands.
- `err_clr`  in  1  clear sticky error.
- `out_valid`  out  1  operands held for the ALU.
- `out_ready`  in  1  ALU consumes operands.
- `alu_src1`  out  WIDTH  registered operand 1.
- `alu_src2`  out  WIDTH  registered operand 2.
- `sel_err`  out  1  sticky illegal-select flag.

## Operation
- Select decode, per operand: 0 gives zero; 1..NSRC give lane code-1; NSRC+1 gives the feedback value; any code above NSRC+1 gives zero and is illegal.
- Feedback value: `res_in` when `res_we` is high in the same cycle (bypass), otherwise `res_q`.
- `res_q` loads `res_in` on every cycle with `res_we`=1, independent of the handshake.
- Accept condition: `in_valid && in_ready`. On accept, `alu_src1` and `alu_src2` load the decoded values and `out_valid` is set.
- Consume condition: `out_valid && out_ready`. It clears `out_valid` unless a new accept happens in the same cycle.
- While `out_valid` is high and `out_ready` is low, both operands hold steady.
- `flush` has priority over accept and consume: the next-cycle `out_valid` is 0, operands keep their old value, and an accept in the flush cycle is dropped. `res_q` still updates on `res_we`.
- `sel_err` is set on an accept where either select is illegal; that transfer still completes with zero in the offending operand.
- `err_clr` clears `sel_err`. When set and clear coincide, set wins.
- Illegal codes arriving without an accept do not set `sel_err`.

## Timing
- Reset values: `out_valid`=0, `alu_src1`=0, `alu_src2`=0, `res_q`=0, `sel_err`=0. `in_ready`=1 immediately after reset.
- `in_ready` = `!out_valid || out_ready`. It is combinational from `out_ready` and gives full throughput with no bubble. `in_ready` does not depend on `flush`.
- Latency: accept in cycle N puts operands on `alu_src*` with `out_valid`=1 in cycle N+1.
- Bypass latency is 0: `res_we` plus an accept with code NSRC+1 in cycle N gives `res_in` of cycle N in the operand at N+1.
- Reset asserted mid-transfer clears everything asynchronously. No transfer completes in a cycle where `rstn` is low.
- All outputs except `in_ready` are registered.

## Test plan
- Reset, then accept with src1_sel=2 and src2_sel=0, src1_bus lane1=0x0000_1000 -> next cycle out_valid=1, alu_src1=0x0000_1000, alu_src2=0, sel_err=0.
- Back-to-back accepts with out_ready=1 on codes 1,2,3 for src2 -> one transfer per cycle with matching lanes. Then out_ready=0 for 3 cycles -> operands stable, in_ready=0, out_valid=1.
- res_we=1, res_in=0xDEAD_BEEF, accept in the same cycle with src1_sel=NSRC+1 -> alu_src1=0xDEAD_BEEF at N+1 (bypass). Next accept with res_we=0 -> still 0xDEAD_BEEF from res_q.
- Accept with src2_sel=NSRC+2 (legal only when it fits in SEL_W, otherwise use all-ones) -> alu_src2=0, sel_err=1 and stays 1. err_clr pulse -> 0. err_clr coinciding with a new illegal accept -> stays 1.
- out_valid=1 with out_ready=0, then flush plus in_valid in the same cycle -> next cycle out_valid=0, alu_src1/alu_src2 unchanged.
- rstn low for half a cycle while out_valid=1 -> out_valid, alu_src1, alu_src2 and sel_err go to 0 without waiting for a clk edge. res_q reads 0 via code NSRC+1 afterwards.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand-select stage: picks ALU source 1/2 from candidate buses or the held
// ALU result, and presents them through a single-entry valid/ready register.
module alu_operand_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 3,
    parameter int unsigned SEL_W = $clog2(NSRC + 2)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      src1_sel,
    input  logic [SEL_W-1:0]      src2_sel,
    input  logic [NSRC*WIDTH-1:0] src1_bus,
    input  logic [NSRC*WIDTH-1:0] src2_bus,
    input  logic                  res_we,
    input  logic [WIDTH-1:0]      res_in,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      alu_src1,
    output logic [WIDTH-1:0]      alu_src2,
    output logic                  sel_err
);

    localparam int unsigned FB_CODE = NSRC + 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_src1_q, alu_src1_d;
    logic [WIDTH-1:0] alu_src2_q, alu_src2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sel_err_q, sel_err_d;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] fb_val;
    logic [WIDTH-1:0] op1_val;
    logic [WIDTH-1:0] op2_val;
    logic             illegal;

    // Code 0 and any code past the feedback code both decode to zero.
    function automatic logic [WIDTH-1:0] decode(
        input logic [SEL_W-1:0]      sel,
        input logic [NSRC*WIDTH-1:0] bus,
        input logic [WIDTH-1:0]      fb
    );
        logic [WIDTH-1:0] val;
        val = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (32'(sel) == k + 1) val = bus[k*WIDTH +: WIDTH];
        end
        if (32'(sel) == FB_CODE) val = fb;
        return val;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        fb_val  = res_we ? res_in : res_q;
        op1_val = decode(src1_sel, src1_bus, fb_val);
        op2_val = decode(src2_sel, src2_bus, fb_val);
        illegal = (32'(src1_sel) > FB_CODE) || (32'(src2_sel) > FB_CODE);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        res_d       = res_we ? res_in : res_q;
        sel_err_d   = sel_err_q;

        // Flush drops both the held entry and any accept in the same cycle.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_src1_d  = op1_val;
            alu_src2_d  = op2_val;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        if (accept && !flush && illegal) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            res_q       <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            res_q       <= res_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_src1  = alu_src1_q;
    assign alu_src2  = alu_src2_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table plus hand sequences, with a
// reference model and scoreboard queue for held operands.
module tb_alu_operand_stage;

    localparam int W    = 32;
    localparam int NSRC = 3;
    localparam int SW   = $clog2(NSRC + 2);

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [SW-1:0]     src1_sel;
    logic [SW-1:0]     src2_sel;
    logic [NSRC*W-1:0] src1_bus;
    logic [NSRC*W-1:0] src2_bus;
    logic              res_we;
    logic [W-1:0]      res_in;
    logic              flush;
    logic              err_clr;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      alu_src1;
    logic [W-1:0]      alu_src2;
    logic              sel_err;

    alu_operand_stage #(.WIDTH(W), .NSRC(NSRC)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .src1_sel (src1_sel),
        .src2_sel (src2_sel),
        .src1_bus (src1_bus),
        .src2_bus (src2_bus),
        .res_we   (res_we),
        .res_in   (res_in),
        .flush    (flush),
        .err_clr  (err_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_src1 (alu_src1),
        .alu_src2 (alu_src2),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    typedef struct {
        int           s1;
        int           s2;
        logic         rw;
        logic [W-1:0] ri;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    pair_t        sb[$];
    logic         m_valid;
    logic         m_err;
    logic [W-1:0] m_res;
    pair_t        m_last;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_dec(input int s, input logic [NSRC*W-1:0] bus,
                                              input logic [W-1:0] fb);
        if (s == 0) return '0;
        if (s <= NSRC) return bus[(s-1)*W +: W];
        if (s == NSRC + 1) return fb;
        return '0;
    endfunction

    task automatic drive(input logic v, input int s1, input int s2, input logic rw,
                         input logic [W-1:0] ri, input logic ordy, input logic fl,
                         input logic ec);
        in_valid  = v;
        src1_sel  = SW'(s1);
        src2_sel  = SW'(s2);
        res_we    = rw;
        res_in    = ri;
        out_ready = ordy;
        flush     = fl;
        err_clr   = ec;
    endtask

    // Entered at a negedge with inputs applied; leaves at the following negedge.
    task automatic tick();
        logic         exp_ready, acc, cons, bad;
        logic [W-1:0] fb;
        int           s1, s2;
        pair_t        p;
        #1;
        s1 = int'(src1_sel);
        s2 = int'(src2_sel);
        exp_ready = !m_valid || out_ready;
        chk("in_ready", W'(in_ready), W'(exp_ready));
        chk("out_valid", W'(out_valid), W'(m_valid));
        chk("sel_err", W'(sel_err), W'(m_err));
        chk("alu_src1_held", alu_src1, m_last.a);
        chk("alu_src2_held", alu_src2, m_last.b);
        acc  = in_valid && exp_ready && !flush;
        cons = m_valid && out_ready && !flush;
        bad  = (s1 > NSRC + 1) || (s2 > NSRC + 1);
        fb   = res_we ? res_in : m_res;
        if (cons) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                p = sb.pop_front();
                chk("consume_src1", alu_src1, p.a);
                chk("consume_src2", alu_src2, p.b);
            end
        end
        if (flush && m_valid && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            p.a = model_dec(s1, src1_bus, fb);
            p.b = model_dec(s2, src2_bus, fb);
            sb.push_back(p);
            m_last = p;
        end
        @(posedge clk);
        #1;
        if (flush) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (cons) m_valid = 1'b0;
        if (acc && bad) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_res = fb;
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2, 0, 1'b0, 32'h0,         32'h0000_1000, 32'h0};
        vecs[1] = '{1, 1, 1'b0, 32'h0,         32'h1111_0000, 32'hAAAA_0001};
        vecs[2] = '{3, 2, 1'b0, 32'h0,         32'h3333_0000, 32'hBBBB_0002};
        vecs[3] = '{0, 3, 1'b0, 32'h0,         32'h0,         32'hCCCC_0003};
        vecs[4] = '{4, 0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
        vecs[5] = '{4, 4, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[6] = '{4, 1, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'hAAAA_0001};

        src1_bus = {32'h3333_0000, 32'h0000_1000, 32'h1111_0000};
        src2_bus = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        drive(0, 0, 0, 0, '0, 1, 0, 0);
        m_valid = 0; m_err = 0; m_res = '0; m_last = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Reset state
        tick();

        // Table: back-to-back accepts with out_ready held high
        for (int i = 0; i < 7; i++) begin
            drive(1, vecs[i].s1, vecs[i].s2, vecs[i].rw, vecs[i].ri, 1, 0, 0);
            tick();
            chk($sformatf("vec%0d_src1", i), alu_src1, vecs[i].e1);
            chk($sformatf("vec%0d_src2", i), alu_src2, vecs[i].e2);
            chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(1));
        end

        // Stall: three cycles with out_ready low and new requests pending
        drive(1, 2, 3, 0, '0, 1, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, '0, 0, 0, 0); tick();
        end
        chk("stall_src1", alu_src1, 32'h0000_1000);
        chk("stall_src2", alu_src2, 32'hCCCC_0003);
        drive(0, 0, 0, 0, '0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, '0, 1, 0, 0); tick();

        // Illegal select sets sticky error; clear; set wins over clear
        drive(1, 1, NSRC + 2, 0, '0, 1, 0, 0); tick();
        chk("illegal_src2_zero", alu_src2, 32'h0);
        chk("illegal_sets_err", W'(sel_err), W'(1));
        drive(1, 1, 1, 0, '0, 1, 0, 0); tick();
        chk("err_sticky", W'(sel_err), W'(1));
        drive(0, 0, 0, 0, '0, 1, 0, 1); tick();
        chk("err_cleared", W'(sel_err), W'(0));
        drive(1, 7, 2, 0, '0, 1, 0, 1); tick();
        chk("err_set_wins", W'(sel_err), W'(1));
        drive(0, 0, 0, 0, '0, 1, 0, 1); tick();
        // Illegal code while stalled is not an accept
        drive(1, 3, 3, 0, '0, 1, 0, 0); tick();
        drive(1, 6, 6, 0, '0, 0, 0, 0); tick();
        chk("no_err_without_accept", W'(sel_err), W'(0));
        drive(0, 0, 0, 0, '0, 1, 0, 0); tick();

        // Flush while stalled, with a concurrent request and feedback write
        drive(1, 1, 2, 0, '0, 1, 0, 0); tick();
        drive(1, 3, 3, 1, 32'h5A5A_A5A5, 0, 1, 0); tick();
        chk("flush_valid", W'(out_valid), W'(0));
        chk("flush_src1_kept", alu_src1, 32'h1111_0000);
        chk("flush_src2_kept", alu_src2, 32'hBBBB_0002);
        drive(0, 0, 0, 0, '0, 0, 0, 0); tick();
        drive(1, NSRC + 1, 0, 0, '0, 1, 0, 0); tick();
        chk("res_after_flush", alu_src1, 32'h5A5A_A5A5);

        // Asynchronous reset mid-transfer
        drive(1, 2, 7, 0, '0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, '0, 0, 0, 0);
        #1 rstn = 1'b0;
        #1;
        chk("arst_valid", W'(out_valid), W'(0));
        chk("arst_src1", alu_src1, 32'h0);
        chk("arst_src2", alu_src2, 32'h0);
        chk("arst_err", W'(sel_err), W'(0));
        #2 rstn = 1'b1;
        m_valid = 0; m_err = 0; m_res = '0; m_last = '0;
        sb.delete();
        @(negedge clk);
        drive(1, NSRC + 1, 1, 0, '0, 1, 0, 0); tick();
        chk("res_q_reset", alu_src1, 32'h0);
        chk("post_reset_src2", alu_src2, 32'hAAAA_0001);
        drive(0, 0, 0, 0, '0, 1, 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
